// File: rtl/holy_axi_burst_ram.sv
// AXI4 slave burst memory: INCR/FIXED bursts on independent read and write channels,
// backed by four byte-lane word arrays with a registered read-data path.
module holy_axi_burst_ram #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          ID_WIDTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLV  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    // ---------------- write channel state ----------------
    w_state_t            w_state_reg, w_state_next;
    logic [ID_WIDTH-1:0] aw_id_reg, aw_id_next;
    logic [31:0]         aw_addr_reg, aw_addr_next;
    logic [7:0]          aw_len_reg, aw_len_next;
    logic                aw_fixed_reg, aw_fixed_next;
    logic [7:0]          w_cnt_reg, w_cnt_next;
    logic                w_err_reg, w_err_next;
    logic                mem_we;

    // Subtracting the base first makes addresses below BASE_ADDR wrap to huge offsets,
    // so a single unsigned compare covers both range limits.
    logic [31:0]         w_off;
    logic                w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic                w_last_beat;

    assign w_off       = aw_addr_reg - BASE_ADDR;
    assign w_in_range  = (w_off < MEM_BYTES);
    assign w_idx       = w_off[IDX_W+1:2];
    assign w_last_beat = (w_cnt_reg == aw_len_reg);

    assign s_axi_awready = (w_state_reg == W_IDLE);
    assign s_axi_wready  = (w_state_reg == W_DATA);
    assign s_axi_bvalid  = (w_state_reg == W_RESP);
    assign s_axi_bid     = aw_id_reg;
    assign s_axi_bresp   = (s_axi_bvalid && w_err_reg) ? RESP_SLV : RESP_OKAY;

    always_comb begin
        w_state_next  = w_state_reg;
        aw_id_next    = aw_id_reg;
        aw_addr_next  = aw_addr_reg;
        aw_len_next   = aw_len_reg;
        aw_fixed_next = aw_fixed_reg;
        w_cnt_next    = w_cnt_reg;
        w_err_next    = w_err_reg;
        mem_we        = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (s_axi_awvalid) begin
                    aw_id_next    = s_axi_awid;
                    aw_addr_next  = s_axi_awaddr;
                    aw_len_next   = s_axi_awlen;
                    aw_fixed_next = (s_axi_awburst == 2'b00);
                    w_cnt_next    = 8'd0;
                    w_err_next    = (s_axi_awsize != 3'b010);
                    w_state_next  = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid) begin
                    mem_we     = w_in_range;
                    // The beat count decides the burst end; a disagreeing wlast only flags an error.
                    w_err_next = w_err_reg | ~w_in_range | (s_axi_wlast != w_last_beat);
                    if (!aw_fixed_reg) begin
                        aw_addr_next = aw_addr_reg + 32'd4;
                    end
                    w_cnt_next = w_cnt_reg + 8'd1;
                    if (w_last_beat) begin
                        w_state_next = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // ---------------- read channel state ----------------
    r_state_t            r_state_reg, r_state_next;
    logic [ID_WIDTH-1:0] ar_id_reg, ar_id_next;
    logic [31:0]         r_addr_reg, r_addr_next;
    logic [7:0]          r_len_reg, r_len_next;
    logic                r_fixed_reg, r_fixed_next;
    logic [7:0]          r_cnt_reg, r_cnt_next;
    logic                r_size_err_reg, r_size_err_next;
    logic [31:0]         rdata_reg, rdata_next;
    logic [1:0]          rresp_reg, rresp_next;
    logic                rlast_reg, rlast_next;
    logic                r_load;
    logic [31:0]         rd_addr;
    logic [31:0]         rd_off;
    logic                rd_in_range;
    logic [IDX_W-1:0]    rd_idx;
    logic [31:0]         rd_word;

    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_in_range = (rd_off < MEM_BYTES);
    assign rd_idx      = rd_off[IDX_W+1:2];

    assign s_axi_arready = (r_state_reg == R_IDLE);
    assign s_axi_rvalid  = (r_state_reg == R_DATA);
    assign s_axi_rid     = ar_id_reg;
    assign s_axi_rdata   = rdata_reg;
    assign s_axi_rresp   = rresp_reg;
    assign s_axi_rlast   = rlast_reg;

    always_comb begin
        r_state_next    = r_state_reg;
        ar_id_next      = ar_id_reg;
        r_addr_next     = r_addr_reg;
        r_len_next      = r_len_reg;
        r_fixed_next    = r_fixed_reg;
        r_cnt_next      = r_cnt_reg;
        r_size_err_next = r_size_err_reg;
        rlast_next      = rlast_reg;
        rd_addr         = r_addr_reg;
        r_load          = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                if (s_axi_arvalid) begin
                    ar_id_next      = s_axi_arid;
                    r_len_next      = s_axi_arlen;
                    r_fixed_next    = (s_axi_arburst == 2'b00);
                    r_cnt_next      = 8'd0;
                    r_size_err_next = (s_axi_arsize != 3'b010);
                    rd_addr         = s_axi_araddr;
                    r_addr_next     = s_axi_araddr;
                    rlast_next      = (s_axi_arlen == 8'd0);
                    r_load          = 1'b1;
                    r_state_next    = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi_rready) begin
                    if (rlast_reg) begin
                        rlast_next   = 1'b0;
                        r_state_next = R_IDLE;
                    end else begin
                        rd_addr     = r_fixed_reg ? r_addr_reg : r_addr_reg + 32'd4;
                        r_addr_next = rd_addr;
                        r_cnt_next  = r_cnt_reg + 8'd1;
                        rlast_next  = ((r_cnt_reg + 8'd1) == r_len_reg);
                        r_load      = 1'b1;
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Beat data is staged into the output register in the same cycle the beat is
    // addressed, so a concurrent write to that word is seen only by later beats.
    always_comb begin
        rdata_next = rdata_reg;
        rresp_next = rresp_reg;
        if (r_load) begin
            if (r_size_err_next || !rd_in_range) begin
                rdata_next = 32'd0;
                rresp_next = RESP_SLV;
            end else begin
                rdata_next = rd_word;
                rresp_next = RESP_OKAY;
            end
        end
    end

    // ---------------- storage: one byte-wide array per lane ----------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_WORDS];

            always_ff @(posedge clk) begin
                if (mem_we && s_axi_wstrb[gi]) begin
                    lane_mem[w_idx] <= s_axi_wdata[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[rd_idx];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_reg    <= W_IDLE;
            aw_id_reg      <= '0;
            aw_addr_reg    <= 32'd0;
            aw_len_reg     <= 8'd0;
            aw_fixed_reg   <= 1'b0;
            w_cnt_reg      <= 8'd0;
            w_err_reg      <= 1'b0;
            r_state_reg    <= R_IDLE;
            ar_id_reg      <= '0;
            r_addr_reg     <= 32'd0;
            r_len_reg      <= 8'd0;
            r_fixed_reg    <= 1'b0;
            r_cnt_reg      <= 8'd0;
            r_size_err_reg <= 1'b0;
            rdata_reg      <= 32'd0;
            rresp_reg      <= RESP_OKAY;
            rlast_reg      <= 1'b0;
        end else begin
            w_state_reg    <= w_state_next;
            aw_id_reg      <= aw_id_next;
            aw_addr_reg    <= aw_addr_next;
            aw_len_reg     <= aw_len_next;
            aw_fixed_reg   <= aw_fixed_next;
            w_cnt_reg      <= w_cnt_next;
            w_err_reg      <= w_err_next;
            r_state_reg    <= r_state_next;
            ar_id_reg      <= ar_id_next;
            r_addr_reg     <= r_addr_next;
            r_len_reg      <= r_len_next;
            r_fixed_reg    <= r_fixed_next;
            r_cnt_reg      <= r_cnt_next;
            r_size_err_reg <= r_size_err_next;
            rdata_reg      <= rdata_next;
            rresp_reg      <= rresp_next;
            rlast_reg      <= rlast_next;
        end
    end

endmodule

// File: tb/tb_holy_axi_burst_ram.sv
// Directed bench for holy_axi_burst_ram: bursts, strobes, stalls, range errors,
// FIXED bursts with a concurrent read, and reset in the middle of a read burst.
module tb_holy_axi_burst_ram;
    logic        clk;
    logic        rst_n;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    holy_axi_burst_ram dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
        .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
        .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_data [256];
    logic [3:0]  wr_strb [256];
    logic [31:0] rd_data [$];
    logic [1:0]  rd_resp [$];
    logic        rd_last [$];
    logic [3:0]  rd_id   [$];
    int          stall_viol;
    logic        ar_lat_ok;
    int          b_lat;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    task automatic timeout_fail(input string what);
        checks++;
        errors++;
        $display("FAIL timeout_%s: waited too long, required handshake", what);
    endtask

    task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [2:0] size, input bit bad_last);
        int n;
        int t_aw;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout_fail("aw");
        @(posedge clk); #1;
        t_aw = cycle;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wr_data[i];
            wstrb = wr_strb[i];
            wlast = (i == int'(len)) ^ (bad_last && i == 0);
            wvalid = 1'b1;
            n = 0;
            while (!wready && n < 100) begin @(posedge clk); #1; n++; end
            if (n >= 100) timeout_fail("w");
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout_fail("b");
        b_lat = cycle - t_aw;
        b_resp = bresp;
        b_id = bid;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        $display("write addr=%h len=%0d bresp=%b bid=%0d latency=%0d", addr, len, b_resp, b_id, b_lat);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input logic [2:0] size, input bit stall);
        int n;
        logic [31:0] pd;
        logic [1:0] pr;
        logic pl;
        bit pstall;
        rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete();
        stall_viol = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout_fail("ar");
        @(posedge clk); #1;
        arvalid = 1'b0;
        ar_lat_ok = rvalid;
        n = 0;
        pstall = 0;
        pd = '0; pr = '0; pl = 1'b0;
        while (rd_data.size() < int'(len) + 1 && n < 2000) begin
            rready = stall ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
            if (pstall && rvalid && (rdata !== pd || rresp !== pr || rlast !== pl)) stall_viol++;
            pstall = rvalid && !rready;
            pd = rdata; pr = rresp; pl = rlast;
            if (rvalid && rready) begin
                rd_data.push_back(rdata);
                rd_resp.push_back(rresp);
                rd_last.push_back(rlast);
                rd_id.push_back(rid);
            end
            @(posedge clk); #1;
            n++;
        end
        rready = 1'b0;
        if (n >= 2000) timeout_fail("r");
        $display("read addr=%h len=%0d beats=%0d first=%h", addr, len, rd_data.size(),
                 (rd_data.size() > 0) ? rd_data[0] : 32'h0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rvalid !== 1'b0 || bvalid !== 1'b0 || wready !== 1'b0) begin
            errors++; $display("FAIL reset_valids: rvalid=%b bvalid=%b wready=%b required 0 0 0", rvalid, bvalid, wready);
        end
        rst_n = 1'b1;
        #1;
        checks++; if (awready !== 1'b1 || arready !== 1'b1) begin
            errors++; $display("FAIL reset_readies: awready=%b arready=%b required 1 1", awready, arready);
        end
        checks++; if (rdata !== 32'd0 || rlast !== 1'b0 || rresp !== 2'd0 || rid !== 4'd0) begin
            errors++; $display("FAIL reset_r: rdata=%h rlast=%b rresp=%b rid=%h required 0", rdata, rlast, rresp, rid);
        end
        checks++; if (bresp !== 2'd0 || bid !== 4'd0) begin
            errors++; $display("FAIL reset_b: bresp=%b bid=%h required 0", bresp, bid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_incr_burst;
        logic [31:0] exp [4];
        exp[0] = 32'h11; exp[1] = 32'h22; exp[2] = 32'h33; exp[3] = 32'h44;
        for (int i = 0; i < 4; i++) begin wr_data[i] = exp[i]; wr_strb[i] = 4'hF; end
        write_burst(4'd3, 32'h8000_0000, 8'd3, 2'b01, 3'b010, 0);
        checks++; if (b_resp !== 2'b00 || b_id !== 4'd3) begin
            errors++; $display("FAIL incr_bresp: bresp=%b bid=%0d required 00 3", b_resp, b_id);
        end
        checks++; if (b_lat !== 4) begin
            errors++; $display("FAIL incr_b_latency: %0d cycles required 4", b_lat);
        end
        read_burst(4'd5, 32'h8000_0000, 8'd3, 2'b01, 3'b010, 0);
        checks++; if (ar_lat_ok !== 1'b1) begin
            errors++; $display("FAIL incr_r_latency: rvalid=%b one cycle after AR required 1", ar_lat_ok);
        end
        checks++; if (rd_data.size() != 4) begin
            errors++; $display("FAIL incr_beats: %0d required 4", rd_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (rd_data[i] !== exp[i] || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3) || rd_id[i] !== 4'd5) begin
                    errors++; $display("FAIL incr_beat%0d: data=%h resp=%b last=%b id=%0d required %h 00 %b 5",
                                       i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], exp[i], (i == 3));
                end
            end
        end
    endtask

    task automatic test_strobes;
        wr_data[0] = 32'hAABB_CCDD; wr_strb[0] = 4'hF;
        write_burst(4'd1, 32'h8000_0010, 8'd0, 2'b01, 3'b010, 0);
        wr_data[0] = 32'h1122_3344; wr_strb[0] = 4'b0101;
        write_burst(4'd2, 32'h8000_0010, 8'd0, 2'b01, 3'b010, 0);
        read_burst(4'd0, 32'h8000_0010, 8'd0, 2'b01, 3'b010, 0);
        checks++; if (rd_data.size() != 1 || rd_data[0] !== 32'hAA22_CC44 || rd_last[0] !== 1'b1) begin
            errors++; $display("FAIL strobe_merge: data=%h required aa22cc44 with rlast",
                               (rd_data.size() > 0) ? rd_data[0] : 32'hx);
        end
    endtask

    task automatic test_read_stall;
        for (int i = 0; i < 8; i++) begin wr_data[i] = 32'h100 + 32'(i); wr_strb[i] = 4'hF; end
        write_burst(4'd4, 32'h8000_0040, 8'd7, 2'b01, 3'b010, 0);
        read_burst(4'd9, 32'h8000_0040, 8'd7, 2'b01, 3'b010, 1);
        checks++; if (stall_viol != 0) begin
            errors++; $display("FAIL stall_stable: %0d changes during stalls required 0", stall_viol);
        end
        checks++; if (rd_data.size() != 8) begin
            errors++; $display("FAIL stall_beats: %0d required 8", rd_data.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (rd_data[i] !== 32'h100 + 32'(i) || rd_last[i] !== (i == 7)) begin
                    errors++; $display("FAIL stall_beat%0d: data=%h last=%b required %h %b",
                                       i, rd_data[i], rd_last[i], 32'h100 + 32'(i), (i == 7));
                end
            end
        end
        checks++; if (rvalid !== 1'b0) begin
            errors++; $display("FAIL stall_extra_beat: rvalid=%b after last beat required 0", rvalid);
        end
    endtask

    task automatic test_out_of_range;
        wr_data[0] = 32'h5A5A_5A5A; wr_strb[0] = 4'hF;
        write_burst(4'd0, 32'h8000_1000, 8'd0, 2'b01, 3'b010, 0);
        wr_data[0] = 32'hDEAD_0001; wr_data[1] = 32'hDEAD_0002; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        write_burst(4'd7, 32'h0000_1000, 8'd1, 2'b01, 3'b010, 0);
        checks++; if (b_resp !== 2'b10 || b_id !== 4'd7) begin
            errors++; $display("FAIL oor_bresp: bresp=%b bid=%0d required 10 7", b_resp, b_id);
        end
        read_burst(4'd8, 32'h0000_1000, 8'd1, 2'b01, 3'b010, 0);
        checks++; if (rd_data.size() != 2) begin
            errors++; $display("FAIL oor_beats: %0d required 2", rd_data.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++; if (rd_data[i] !== 32'd0 || rd_resp[i] !== 2'b10) begin
                    errors++; $display("FAIL oor_beat%0d: data=%h resp=%b required 0 10", i, rd_data[i], rd_resp[i]);
                end
            end
        end
        read_burst(4'd0, 32'h8000_1000, 8'd0, 2'b01, 3'b010, 0);
        checks++; if (rd_data.size() != 1 || rd_data[0] !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL oor_no_alias: data=%h required 5a5a5a5a",
                               (rd_data.size() > 0) ? rd_data[0] : 32'hx);
        end
    endtask

    task automatic test_boundary;
        wr_data[0] = 32'hC0DE_0001; wr_data[1] = 32'hC0DE_0002; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        write_burst(4'd2, 32'h8000_3FFC, 8'd1, 2'b01, 3'b010, 0);
        checks++; if (b_resp !== 2'b10) begin
            errors++; $display("FAIL edge_bresp: bresp=%b required 10", b_resp);
        end
        read_burst(4'd2, 32'h8000_3FFC, 8'd1, 2'b01, 3'b010, 0);
        checks++; if (rd_data.size() != 2 || rd_data[0] !== 32'hC0DE_0001 || rd_resp[0] !== 2'b00
                      || rd_data[1] !== 32'd0 || rd_resp[1] !== 2'b10) begin
            errors++; $display("FAIL edge_read: beats=%0d required c0de0001/00 then 0/10", rd_data.size());
        end
        read_burst(4'd3, 32'h8000_0000, 8'd0, 2'b01, 3'b011, 0);
        checks++; if (rd_data.size() != 1 || rd_data[0] !== 32'd0 || rd_resp[0] !== 2'b10) begin
            errors++; $display("FAIL bad_arsize: beats=%0d required data 0 resp 10", rd_data.size());
        end
        wr_data[0] = 32'h1; wr_data[1] = 32'h2;
        write_burst(4'd6, 32'h8000_0080, 8'd1, 2'b01, 3'b010, 1);
        checks++; if (b_resp !== 2'b10) begin
            errors++; $display("FAIL early_wlast: bresp=%b required 10", b_resp);
        end
        wr_data[0] = 32'h3;
        write_burst(4'd6, 32'h8000_0084, 8'd0, 2'b01, 3'b001, 0);
        checks++; if (b_resp !== 2'b10) begin
            errors++; $display("FAIL bad_awsize: bresp=%b required 10", b_resp);
        end
    endtask

    task automatic test_fixed_concurrent;
        for (int i = 0; i < 3; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
        fork
            write_burst(4'd10, 32'h8000_0020, 8'd2, 2'b00, 3'b010, 0);
            read_burst(4'd11, 32'h8000_0000, 8'd3, 2'b01, 3'b010, 0);
        join
        checks++; if (b_resp !== 2'b00 || b_id !== 4'd10) begin
            errors++; $display("FAIL fixed_bresp: bresp=%b bid=%0d required 00 10", b_resp, b_id);
        end
        checks++; if (rd_data.size() != 4 || rd_data[0] !== 32'h11 || rd_data[3] !== 32'h44
                      || rd_last[3] !== 1'b1 || rd_id[0] !== 4'd11) begin
            errors++; $display("FAIL concurrent_read: beats=%0d first=%h required 4 beats 11..44",
                               rd_data.size(), (rd_data.size() > 0) ? rd_data[0] : 32'hx);
        end
        read_burst(4'd1, 32'h8000_0020, 8'd1, 2'b00, 3'b010, 0);
        checks++; if (rd_data.size() != 2 || rd_data[0] !== 32'd3 || rd_data[1] !== 32'd3) begin
            errors++; $display("FAIL fixed_word: data=%h required 3 on both FIXED beats",
                               (rd_data.size() > 0) ? rd_data[0] : 32'hx);
        end
    endtask

    task automatic test_reset_mid_burst;
        int n;
        arid = 4'd6; araddr = 32'h8000_0000; arlen = 8'd3; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) timeout_fail("ar_rst");
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        @(posedge clk); #1;
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h22) begin
            errors++; $display("FAIL rst_pre_beat2: rvalid=%b rdata=%h required 1 22", rvalid, rdata);
        end
        rready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin
            errors++; $display("FAIL rst_async: rvalid=%b rlast=%b required 0 0", rvalid, rlast);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (arready !== 1'b1 || awready !== 1'b1 || rvalid !== 1'b0) begin
            errors++; $display("FAIL rst_release: arready=%b awready=%b rvalid=%b required 1 1 0", arready, awready, rvalid);
        end
        @(posedge clk); #1;
        read_burst(4'd2, 32'h8000_0000, 8'd3, 2'b01, 3'b010, 0);
        checks++; if (rd_data.size() != 4 || rd_data[0] !== 32'h11 || rd_data[1] !== 32'h22
                      || rd_data[2] !== 32'h33 || rd_data[3] !== 32'h44) begin
            errors++; $display("FAIL rst_mem_intact: beats=%0d required 11 22 33 44", rd_data.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'b010; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'b010; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;
        test_reset();
        test_incr_burst();
        test_strobes();
        test_read_stall();
        test_out_of_range();
        test_boundary();
        test_fixed_concurrent();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
